// File: rtl/free_list.sv
// Physical-register free list feeding rename.
// A circular FIFO of free register indices hands out one register per cycle.
// A shadow bitmap records which registers currently sit in the FIFO, so that
// commit and rollback frees of registers that are already free can be caught.
module free_list #(
  parameter int PREG_W   = 7,
  parameter int NUM_PREG = 128,
  parameter int NUM_AREG = 64,
  parameter int DEPTH    = NUM_PREG - NUM_AREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_ready,
  output logic [PREG_W-1:0] alloc_preg,
  input  logic              commit_wb_en,
  input  logic [PREG_W-1:0] commit_P_rd_old,
  input  logic              rollback_en_0,
  input  logic [PREG_W-1:0] rollback_P_rd_new_0,
  input  logic              rollback_en_1,
  input  logic [PREG_W-1:0] rollback_P_rd_new_1,
  output logic [PREG_W-1:0] free_count,
  output logic              err_overflow,
  output logic              err_double_free
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int NCAND  = 3;

  // Registered state
  logic [PREG_W-1:0]   entry [DEPTH];
  logic [NUM_PREG-1:0] bitmap;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PREG_W-1:0]   count;

  // Per-cycle decisions
  logic                pop;
  logic [PREG_W-1:0]   pop_preg;
  logic [NUM_PREG-1:0] free_eff;
  logic [NUM_PREG-1:0] bitmap_next;
  logic [PREG_W:0]     room;
  logic [1:0]          push_cnt;
  logic [PREG_W-1:0]   count_next;
  logic                dbl_hit;
  logic                ovf_hit;

  // Free candidates in priority order: rollback slot 0, rollback slot 1, commit
  logic [NCAND-1:0]    cand_en;
  logic [PREG_W-1:0]   cand_preg [NCAND];
  logic [NCAND-1:0]    cand_live;
  logic [NCAND-1:0]    cand_dup;
  logic [NCAND-1:0]    cand_valid;
  logic [NCAND-1:0]    cand_wr;
  logic [PTR_W-1:0]    cand_slot [NCAND];

  // Circular pointer advance with explicit wrap at DEPTH (inc is at most NCAND).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [1:0]       inc);
    logic [PTR_W+1:0] sum;
    sum = (PTR_W+2)'(ptr) + (PTR_W+2)'(inc);
    if (sum >= (PTR_W+2)'(DEPTH)) sum = sum - (PTR_W+2)'(DEPTH);
    return PTR_W'(sum);
  endfunction

  assign cand_en      = {commit_wb_en, rollback_en_1, rollback_en_0};
  assign cand_preg[0] = rollback_P_rd_new_0;
  assign cand_preg[1] = rollback_P_rd_new_1;
  assign cand_preg[2] = commit_P_rd_old;

  // Grant side is purely combinational from registered state: zero-latency.
  assign alloc_ready = (count != '0);
  assign alloc_preg  = entry[head];
  assign free_count  = count;
  assign pop         = alloc_req && alloc_ready;
  assign pop_preg    = entry[head];

  // Classify free candidates, compact valid ones onto the tail, detect errors.
  always_comb begin
    free_eff = bitmap;
    if (pop) free_eff[pop_preg] = 1'b0;
    bitmap_next = free_eff;
    room     = (PREG_W+1)'(DEPTH) - (PREG_W+1)'(count) + (PREG_W+1)'(pop);
    push_cnt = '0;
    dbl_hit  = 1'b0;
    ovf_hit  = 1'b0;
    cand_live  = '0;
    cand_dup   = '0;
    cand_valid = '0;
    cand_wr    = '0;
    for (int k = 0; k < NCAND; k++) cand_slot[k] = tail;

    for (int k = 0; k < NCAND; k++) begin
      // P0 is the hardwired zero register: freeing it is silently ignored
      cand_live[k] = cand_en[k] && (cand_preg[k] != '0);
      for (int j = 0; j < k; j++) begin
        if (cand_valid[j] && (cand_preg[j] == cand_preg[k])) cand_dup[k] = 1'b1;
      end
      // A register granted this cycle already counts as not free here
      cand_valid[k] = cand_live[k] && !free_eff[cand_preg[k]] && !cand_dup[k];
      if (cand_live[k] && !cand_valid[k]) dbl_hit = 1'b1;
      if (cand_valid[k]) begin
        if ((PREG_W+1)'(push_cnt) < room) begin
          cand_wr[k]   = 1'b1;
          cand_slot[k] = ptr_add(tail, push_cnt);
          bitmap_next[cand_preg[k]] = 1'b1;
          push_cnt     = push_cnt + 2'd1;
        end else begin
          // Out of room: later candidates (commit first) are the ones lost
          ovf_hit = 1'b1;
        end
      end
    end

    count_next = count - PREG_W'(pop) + PREG_W'(push_cnt);
  end

  // State update: reset refills the FIFO with the unmapped registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= PREG_W'(DEPTH);
      bitmap          <= {{DEPTH{1'b1}}, {NUM_AREG{1'b0}}};
      err_overflow    <= 1'b0;
      err_double_free <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= PREG_W'(NUM_AREG + i);
    end else begin
      if (pop) head <= ptr_add(head, 2'd1);
      tail            <= ptr_add(tail, push_cnt);
      count           <= count_next;
      bitmap          <= bitmap_next;
      err_overflow    <= err_overflow | ovf_hit;
      err_double_free <= err_double_free | dbl_hit;
      for (int k = 0; k < NCAND; k++) begin
        if (cand_wr[k]) entry[cand_slot[k]] <= cand_preg[k];
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios followed by randomized traffic,
// all compared against a queue-based model of the free pool.
module tb_free_list;

  localparam int PREG_W   = 7;
  localparam int NUM_AREG = 64;
  localparam int DEPTH    = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_req;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_preg;
  logic              commit_wb_en;
  logic [PREG_W-1:0] commit_P_rd_old;
  logic              rollback_en_0;
  logic [PREG_W-1:0] rollback_P_rd_new_0;
  logic              rollback_en_1;
  logic [PREG_W-1:0] rollback_P_rd_new_1;
  logic [PREG_W-1:0] free_count;
  logic              err_overflow;
  logic              err_double_free;

  int checks = 0;
  int errors = 0;

  // Reference model: the free pool as an ordered queue plus sticky flags
  int unsigned fq[$];
  bit          m_ovf;
  bit          m_dbl;
  // Registers currently held by "rename", used to generate legal frees
  int unsigned pool[$];
  int          last_grant;

  free_list dut (
    .clk                 (clk),
    .rst                 (rst),
    .alloc_req           (alloc_req),
    .alloc_ready         (alloc_ready),
    .alloc_preg          (alloc_preg),
    .commit_wb_en        (commit_wb_en),
    .commit_P_rd_old     (commit_P_rd_old),
    .rollback_en_0       (rollback_en_0),
    .rollback_P_rd_new_0 (rollback_P_rd_new_0),
    .rollback_en_1       (rollback_en_1),
    .rollback_P_rd_new_1 (rollback_P_rd_new_1),
    .free_count          (free_count),
    .err_overflow        (err_overflow),
    .err_double_free     (err_double_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_list(input int unsigned q[$], input int unsigned v);
    for (int i = 0; i < q.size(); i++) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < DEPTH; i++) fq.push_back(NUM_AREG + i);
    pool.delete();
    for (int i = 1; i < NUM_AREG; i++) pool.push_back(i);
    m_ovf = 1'b0;
    m_dbl = 1'b0;
  endtask

  // One cycle of the pool: take from the front, then accept frees in order.
  task automatic model_step(input bit req, input bit e0, input int unsigned p0,
                            input bit e1, input int unsigned p1,
                            input bit ec, input int unsigned pc, output int grant);
    int unsigned acc[$];
    bit          en[3];
    int unsigned pr[3];
    en = '{e0, e1, ec};
    pr = '{p0, p1, pc};
    grant = -1;
    if (req && fq.size() != 0) grant = int'(fq.pop_front());
    for (int k = 0; k < 3; k++) begin
      if (en[k] && pr[k] != 0) begin
        if (in_list(fq, pr[k]) || in_list(acc, pr[k])) m_dbl = 1'b1;
        else acc.push_back(pr[k]);
      end
    end
    for (int i = 0; i < acc.size(); i++) begin
      if (fq.size() < DEPTH) fq.push_back(acc[i]);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic drive_idle();
    alloc_req = 1'b0;
    rollback_en_0 = 1'b0; rollback_P_rd_new_0 = '0;
    rollback_en_1 = 1'b0; rollback_P_rd_new_1 = '0;
    commit_wb_en  = 1'b0; commit_P_rd_old     = '0;
  endtask

  // Called 1 time unit after a rising edge; returns there one cycle later.
  task automatic step(input bit req, input bit e0, input int unsigned p0,
                      input bit e1, input int unsigned p1,
                      input bit ec, input int unsigned pc);
    int g;
    alloc_req = req;
    rollback_en_0 = e0; rollback_P_rd_new_0 = PREG_W'(p0);
    rollback_en_1 = e1; rollback_P_rd_new_1 = PREG_W'(p1);
    commit_wb_en  = ec; commit_P_rd_old     = PREG_W'(pc);
    #1;
    chk("ready", 32'(alloc_ready), 32'(fq.size() != 0));
    last_grant = -1;
    if (fq.size() != 0) begin
      chk("head", 32'(alloc_preg), fq[0]);
      if (req) last_grant = int'(alloc_preg);
    end
    model_step(req, e0, p0, e1, p1, ec, pc, g);
    if (g >= 0) pool.push_back(g);
    @(posedge clk); #1;
    chk("count", 32'(free_count), 32'(fq.size()));
    chk("ovf", 32'(err_overflow), 32'(m_ovf));
    chk("dbl", 32'(err_double_free), 32'(m_dbl));
  endtask

  task automatic apply_reset(input bit busy);
    rst = 1'b1;
    if (busy) begin
      alloc_req = 1'b1;
      rollback_en_0 = 1'b1; rollback_P_rd_new_0 = PREG_W'($urandom_range(0, 127));
      rollback_en_1 = 1'b1; rollback_P_rd_new_1 = PREG_W'($urandom_range(0, 127));
      commit_wb_en  = 1'b1; commit_P_rd_old     = PREG_W'($urandom_range(0, 127));
    end else begin
      drive_idle();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    model_reset();
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_preg", 32'(alloc_preg), 32'd64);
    chk("rst_count", 32'(free_count), 32'd64);
    chk("rst_ovf", 32'(err_overflow), 32'd0);
    chk("rst_dbl", 32'(err_double_free), 32'd0);
  endtask

  initial begin
    int unsigned exp_g[3];
    int unsigned v;
    int          idx;
    int          slot;
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    apply_reset(1'b0);

    // Three grants in a row
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("grant_seq", 32'(last_grant), 32'(64 + i));
    end
    chk("cnt61", 32'(free_count), 32'd61);

    // Drain the list, then a request while empty is ignored
    for (int i = 0; i < 61; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("empty_ready", 32'(alloc_ready), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("empty_cnt", 32'(free_count), 32'd0);

    // A commit free becomes allocatable the next cycle
    step(0, 0, 0, 0, 0, 1, 5);
    chk("c5_ready", 32'(alloc_ready), 32'd1);
    chk("c5_preg", 32'(alloc_preg), 32'd5);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("c5_grant", 32'(last_grant), 32'd5);

    // Three frees in one cycle, granted back in candidate order
    step(0, 1, 70, 1, 71, 1, 3);
    chk("cnt3", 32'(free_count), 32'd3);
    exp_g = '{70, 71, 3};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("order", 32'(last_grant), exp_g[i]);
    end

    // Freeing a register that is already free
    step(0, 0, 0, 0, 0, 1, 80);
    step(0, 1, 80, 0, 0, 0, 0);
    chk("dbl80_cnt", 32'(free_count), 32'd1);
    chk("dbl80_flag", 32'(err_double_free), 32'd1);

    // Both rollback slots name the same allocated register
    apply_reset(1'b0);
    for (int i = 0; i < 27; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 90, 1, 90, 0, 0);
    chk("dup90_cnt", 32'(free_count), 32'd38);
    chk("dup90_flag", 32'(err_double_free), 32'd1);

    // Freeing P0 is a silent no-op
    apply_reset(1'b0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0);
    chk("p0_cnt", 32'(free_count), 32'd63);
    chk("p0_dbl", 32'(err_double_free), 32'd0);
    chk("p0_ovf", 32'(err_overflow), 32'd0);

    // Full list: pop plus push is fine, push alone overflows
    apply_reset(1'b0);
    step(1, 0, 0, 0, 0, 1, 7);
    chk("full_grant", 32'(last_grant), 32'd64);
    chk("full_cnt", 32'(free_count), 32'd64);
    chk("full_noovf", 32'(err_overflow), 32'd0);
    step(0, 0, 0, 0, 0, 1, 8);
    chk("ovf_cnt", 32'(free_count), 32'd64);
    chk("ovf_flag", 32'(err_overflow), 32'd1);

    // Alternate allocate and legal free long enough to wrap both pointers
    apply_reset(1'b0);
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        step(1, 0, 0, 0, 0, 0, 0);
      end else begin
        idx  = $urandom_range(0, pool.size() - 1);
        v    = pool[idx];
        pool.delete(idx);
        slot = $urandom_range(0, 2);
        step(0, slot == 0, v, slot == 1, v, slot == 2, v);
      end
    end
    chk("wrap_dbl", 32'(err_double_free), 32'd0);
    chk("wrap_ovf", 32'(err_overflow), 32'd0);

    // Unconstrained traffic including illegal and simultaneous frees
    for (int i = 0; i < 250; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 127),
           $urandom_range(0, 2) == 0, $urandom_range(0, 127),
           $urandom_range(0, 2) == 0, $urandom_range(0, 127));
    end

    // Reset in the middle of activity
    apply_reset(1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_grant", 32'(last_grant), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the rename/dispatch stage, directly upstream of the reorder buffer.
- Supplies one new physical destination (P_rd_new) per cycle to rename.
- Reclaims physical registers from two sources:
  - ROB commit (P_rd_old of the retiring instruction).
  - ROB rollback (P_rd_new of up to two squashed entries per cycle).
- Implemented as a circular FIFO of free physical-register indices, with a shadow bitmap that detects illegal frees.

Parameters:
PREG_W, 7, width of a physical-register index
NUM_PREG, 128, number of physical registers
NUM_AREG, 64, number of architectural registers (32 int + 32 fp); P0..P63 are mapped at reset
DEPTH, NUM_PREG-NUM_AREG (64), FIFO capacity; maximum number of free registers

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_req  in  1  rename requests one physical register this cycle
alloc_ready  out  1  free list non-empty; alloc_req is accepted only when high
alloc_preg  out  PREG_W  physical register granted (FIFO head); valid when alloc_ready
commit_wb_en  in  1  ROB commit writes a register; free commit_P_rd_old
commit_P_rd_old  in  PREG_W  previous mapping released at commit
rollback_en_0  in  1  squash slot 0 valid; free rollback_P_rd_new_0
rollback_P_rd_new_0  in  PREG_W  squashed allocation, slot 0
rollback_en_1  in  1  squash slot 1 valid; free rollback_P_rd_new_1
rollback_P_rd_new_1  in  PREG_W  squashed allocation, slot 1
free_count  out  PREG_W  number of free registers (0..DEPTH)
err_overflow  out  1  sticky: a push arrived with no room
err_double_free  out  1  sticky: a push named a register already free

Behaviour:
- Reset (rst high at posedge):
  - head=0, tail=0, count=DEPTH.
  - entry[i]=NUM_AREG+i, so the FIFO holds 64..127.
  - Bitmap bits 64..127 set, bits 0..63 clear.
  - err_overflow=0, err_double_free=0.
  - Post-reset outputs: alloc_ready=1, alloc_preg=64, free_count=64.
  - Reset mid-operation discards all state identically, with no special cases.
- Allocation:
  - alloc_ready = (count != 0); alloc_preg = entry[head]. Both are combinational from registered state, so zero-latency grant.
  - pop = alloc_req && alloc_ready. On pop: head wraps modulo DEPTH and the granted bit is cleared in the bitmap.
  - alloc_req with alloc_ready low has no effect. The caller must stall.
  - Registers freed in cycle N are allocatable no earlier than cycle N+1; there is no same-cycle bypass.
- Free pushes: candidates in fixed order are rollback_0, rollback_1, commit. A candidate is valid when:
  - its enable is high,
  - its preg != 0 (P0 is hardwired x0; freeing P0 is silently ignored),
  - its bitmap bit is clear,
  - it does not match an earlier valid candidate in the same cycle.
- Illegal candidates:
  - A candidate that fails only the bitmap or duplicate check is dropped and sets err_double_free.
  - A register popped in the same cycle counts as not free for this check, because its bitmap clear and set happen in the same cycle.
- Writing valid candidates:
  - Written compacted at tail, tail+1, tail+2 (mod DEPTH); tail advances by the number written.
  - The bitmap bit of each pushed register is set.
- Overflow:
  - Room = DEPTH - count + pop.
  - Valid candidates beyond room are dropped in order (commit is dropped first) and set err_overflow.
- Count update: count_next = count - pop + pushes_written.
- Simultaneous events:
  - Pop, commit free and two rollback frees may all occur in one cycle.
  - With count==DEPTH, one pop plus one push is legal. The push writes the slot at tail==head; the read uses the pre-edge value.
- Error flags are sticky until rst.
- Arithmetic: head and tail are log2(DEPTH) bits with explicit wrap; count is PREG_W bits and never exceeds DEPTH.

Test Plan:
- Reset, then alloc_req for 3 cycles -> alloc_preg 64, 65, 66 in successive cycles; free_count 64->61.
- Allocate all 64 -> alloc_ready=0 after the 64th grant; alloc_req next cycle ignored.
  - Then commit_wb_en with P_rd_old=5 -> alloc_ready=1 the following cycle with alloc_preg=5.
- From the empty state, same cycle: rollback_0 = 70, rollback_1 = 71, commit = 3.
  - Next cycle free_count=3; subsequent grants are 70, 71, 3 in that order.
- Illegal frees:
  - Free 80 while 80 is still free -> err_double_free=1, count unchanged.
  - Both rollback slots name 90 (allocated) -> exactly one push, err_double_free=1.
  - Freeing P0 -> no push, no error.
- Full list (count=64) with alloc_req and commit free of 7 in the same cycle -> grant 64, count stays 64, no overflow.
  - Same without alloc_req -> push dropped, err_overflow=1.
- Wrap-around: alternate allocate and free for 200 cycles -> head and tail wrap past 63.
  - Granted sequence matches a reference FIFO model; no errors.
  - Assert rst mid-run -> state returns to the post-reset values above.
